// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and write-back data path.
// Holds the synchronous SRAM read word across stalls, then aligns and
// extends load data and picks the final register-file write value.
// Optional build macro MEM_WB_DEBUG_EN adds the debug_wb_* trace ports
// and the captured PC.
module mem_wb_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic [1:0]  MemRead,
  input  logic        LoadUnsigned,
  input  logic [31:0] Aluout,
  input  logic [4:0]  rd,
  input  logic [31:0] data_sram_rdata,
`ifdef MEM_WB_DEBUG_EN
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
`endif
  output logic        RegWrite_out,
  output logic [4:0]  rd_out,
  output logic [31:0] wb_data
);

  typedef enum logic {LIVE = 1'b0, HELD = 1'b1} state_t;

  logic        valid_q;
  logic        MemtoReg_q;
  logic        RegWrite_q;
  logic [1:0]  MemRead_q;
  logic        LoadUnsigned_q;
  logic [31:0] Aluout_q;
  logic [4:0]  rd_q;
  logic [31:0] hold_q;
  state_t      state_q, state_d;
  logic        hold_en;

  logic [31:0] word_src;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // Pipeline register: flush clears valid (other fields are don't-care
  // and simply hold), stall holds everything, otherwise advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q        <= 1'b0;
      MemtoReg_q     <= 1'b0;
      RegWrite_q     <= 1'b0;
      MemRead_q      <= 2'b00;
      LoadUnsigned_q <= 1'b0;
      Aluout_q       <= 32'h0;
      rd_q           <= 5'd0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q        <= valid_in;
      MemtoReg_q     <= MemtoReg;
      RegWrite_q     <= RegWrite;
      MemRead_q      <= MemRead;
      LoadUnsigned_q <= LoadUnsigned;
      Aluout_q       <= Aluout;
      rd_q           <= rd;
    end
  end

`ifdef MEM_WB_DEBUG_EN
  logic [31:0] pc_q;

  // Captured PC follows the same advance/hold rule; only used for trace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 pc_q <= RESET_PC;
    else if (!flush && !stall)  pc_q <= pc_in;
  end

  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = {4{RegWrite_out}};
  assign debug_wb_rf_wnum  = rd_out;
  assign debug_wb_rf_wdata = wb_data;
`else
  logic unused_pc;
  assign unused_pc = ^pc_in;
`endif

  // Hold FSM state and the captured SRAM word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LIVE;
      hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (hold_en) hold_q <= data_sram_rdata;
    end
  end

  // The SRAM word is only valid for one cycle, so a stalled load must
  // latch it on the first stalled edge and replay it until WB moves on.
  always_comb begin
    state_d = state_q;
    hold_en = 1'b0;
    case (state_q)
      LIVE: if (stall && !flush && valid_q && (MemRead_q != 2'b00)) begin
        hold_en = 1'b1;
        state_d = HELD;
      end
      HELD: if (!stall || flush) state_d = LIVE;
      default: state_d = LIVE;
    endcase
  end

  // Load lane selection and extension; a misaligned half rounds down.
  always_comb begin
    word_src = (state_q == HELD) ? hold_q : data_sram_rdata;
    byte_sel = word_src[7:0];
    case (Aluout_q[1:0])
      2'd0: byte_sel = word_src[7:0];
      2'd1: byte_sel = word_src[15:8];
      2'd2: byte_sel = word_src[23:16];
      2'd3: byte_sel = word_src[31:24];
      default: byte_sel = word_src[7:0];
    endcase
    half_sel = Aluout_q[1] ? word_src[31:16] : word_src[15:0];
    case (MemRead_q)
      2'b01: load_data = {{24{byte_sel[7] & ~LoadUnsigned_q}}, byte_sel};
      2'b10: load_data = {{16{half_sel[15] & ~LoadUnsigned_q}}, half_sel};
      default: load_data = word_src;
    endcase
  end

  assign wb_data      = MemtoReg_q ? load_data : Aluout_q;
  assign RegWrite_out = valid_q & RegWrite_q & (rd_q != 5'd0);
  assign rd_out       = rd_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage.
module tb_mem_wb_stage;

  logic        clk, reset, stall, flush, valid_in;
  logic [31:0] pc_in;
  logic        MemtoReg, RegWrite, LoadUnsigned;
  logic [1:0]  MemRead;
  logic [31:0] Aluout, data_sram_rdata;
  logic [4:0]  rd;
  logic        RegWrite_out;
  logic [4:0]  rd_out;
  logic [31:0] wb_data;
`ifdef MEM_WB_DEBUG_EN
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
`endif

  int checks = 0;
  int errors = 0;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .pc_in(pc_in), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .LoadUnsigned(LoadUnsigned),
    .Aluout(Aluout), .rd(rd), .data_sram_rdata(data_sram_rdata),
`ifdef MEM_WB_DEBUG_EN
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
`endif
    .RegWrite_out(RegWrite_out), .rd_out(rd_out), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic mtr, input logic rw,
                       input logic [1:0] mr, input logic lu,
                       input logic [31:0] alu, input logic [4:0] r);
    valid_in = v; MemtoReg = mtr; RegWrite = rw; MemRead = mr;
    LoadUnsigned = lu; Aluout = alu; rd = r; pc_in = alu + 32'h100;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom), 1'b1, 2'($urandom), 1'($urandom), $urandom, 5'($urandom_range(1, 31)));
      data_sram_rdata = $urandom;
      tick();
      checks++;
      if (RegWrite_out !== 1'b0 || rd_out !== 5'd0 || wb_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs: got we=%b rd=%0d data=%h, want 0/0/0", RegWrite_out, rd_out, wb_data);
      end
    end
    checks++;
    if (dut.state_q !== 1'b0) begin
      errors++; $display("FAIL reset_state: got %b want LIVE(0)", dut.state_q);
    end
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h1234, 5'd5);
    tick();
    checks++;
    if (RegWrite_out !== 1'b1 || rd_out !== 5'd5 || wb_data !== 32'h1234) begin
      errors++;
      $display("FAIL first_add: got we=%b rd=%0d data=%h, want 1/5/00001234", RegWrite_out, rd_out, wb_data);
    end
  endtask

  task automatic test_loads();
    logic [1:0]  mr_t  [7] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b01, 2'b10};
    logic        lu_t  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  a_t   [7] = '{2'd2, 2'd3, 2'd2, 2'd1, 2'd1, 2'd0, 2'd3};
    logic [31:0] exp_t [7] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
                               32'h0000_7F01, 32'h80FF_7F01, 32'h0000_0001,
                               32'hFFFF_80FF};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'b1, mr_t[i], lu_t[i], {30'h0400_0000, a_t[i]}, 5'd10);
      data_sram_rdata = 32'h0;
      tick();
      data_sram_rdata = 32'h80FF_7F01;
      #1;
      checks++;
      if (wb_data !== exp_t[i] || RegWrite_out !== 1'b1) begin
        errors++;
        $display("FAIL load_%0d: got data=%h we=%b, want %h/1", i, wb_data, RegWrite_out, exp_t[i]);
      end
    end
  endtask

  task automatic test_stall_hold();
    drive(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h2000, 5'd9);
    tick();
    data_sram_rdata = 32'hCAFE_0001;
    #1;
    checks++;
    if (wb_data !== 32'hCAFE_0001) begin
      errors++; $display("FAIL hold_first: got %h want cafe0001", wb_data);
    end
    stall = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h55, 5'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (wb_data !== 32'hCAFE_0001 || dut.state_q !== 1'b1 ||
          RegWrite_out !== 1'b1 || rd_out !== 5'd9) begin
        errors++;
        $display("FAIL hold_cycle_%0d: got data=%h st=%b we=%b rd=%0d, want cafe0001/HELD/1/9",
                 i, wb_data, dut.state_q, RegWrite_out, rd_out);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (wb_data !== 32'h55 || rd_out !== 5'd3 || dut.state_q !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got data=%h rd=%0d st=%b, want 00000055/3/LIVE", wb_data, rd_out, dut.state_q);
    end
  endtask

  task automatic test_stall_nonload();
    drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h77AA, 5'd4);
    tick();
    stall = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h1, 5'd1);
    tick();
    checks++;
    if (dut.state_q !== 1'b0 || wb_data !== 32'h77AA || RegWrite_out !== 1'b1) begin
      errors++;
      $display("FAIL stall_nonload: got st=%b data=%h we=%b, want LIVE/000077aa/1", dut.state_q, wb_data, RegWrite_out);
    end
    stall = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    flush = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h7777, 5'd7);
    tick();
    checks++;
    if (RegWrite_out !== 1'b0) begin
      errors++; $display("FAIL flush_bubble: got we=%b want 0", RegWrite_out);
    end
    flush = 1'b0;
    tick();
    checks++;
    if (RegWrite_out !== 1'b1 || rd_out !== 5'd7) begin
      errors++; $display("FAIL flush_after: got we=%b rd=%0d want 1/7", RegWrite_out, rd_out);
    end
    // load in WB, stall into HELD, then stall+flush together
    drive(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h3000, 5'd7);
    tick();
    stall = 1'b1;
    tick();
    checks++;
    if (dut.state_q !== 1'b1) begin
      errors++; $display("FAIL flush_pre_held: got st=%b want HELD", dut.state_q);
    end
    flush = 1'b1;
    tick();
    checks++;
    if (RegWrite_out !== 1'b0 || dut.state_q !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got we=%b st=%b want 0/LIVE", RegWrite_out, dut.state_q);
    end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_rd_zero();
    drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'hABCD, 5'd0);
    tick();
    checks++;
    if (RegWrite_out !== 1'b0 || wb_data !== 32'hABCD) begin
      errors++;
      $display("FAIL rd_zero: got we=%b data=%h want 0/0000abcd", RegWrite_out, wb_data);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h4000, 5'd12);
    tick();
    data_sram_rdata = 32'h1357_9BDF;
    stall = 1'b1;
    tick();
    checks++;
    if (dut.state_q !== 1'b1 || wb_data !== 32'h1357_9BDF) begin
      errors++;
      $display("FAIL async_pre: got st=%b data=%h want HELD/13579bdf", dut.state_q, wb_data);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (RegWrite_out !== 1'b0 || rd_out !== 5'd0 || wb_data !== 32'h0 || dut.state_q !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got we=%b rd=%0d data=%h st=%b want 0/0/0/LIVE",
               RegWrite_out, rd_out, wb_data, dut.state_q);
    end
    stall = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    data_sram_rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 5'd0);
    test_reset();
    test_loads();
    test_stall_hold();
    test_stall_nonload();
    test_flush();
    test_rd_zero();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

- MEM/WB pipeline register plus write-back data path for the five-stage core; sits directly downstream of the memory stage and drives the register-file write port.
- Captures the memory stage's control, ALU result and destination register on each advancing clock edge.
- Holds the synchronous data-SRAM read word across stalls, then aligns and sign/zero-extends load data.
- Selects the final write-back value and write enable.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, value of the captured PC after reset (debug use only).

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit: hold the MEM/WB register (WB does not advance)
- flush  in  1  insert a bubble into WB on the next edge
- valid_in  in  1  MEM stage holds a real instruction
- pc_in  in  32  PC of the MEM-stage instruction
- MemtoReg  in  1  write-back selects load data
- RegWrite  in  1  instruction writes a register
- MemRead  in  2  00 none, 01 byte, 10 half, 11 word
- LoadUnsigned  in  1  zero-extend byte/half loads
- Aluout  in  32  ALU result / memory address
- rd  in  5  destination register
- data_sram_rdata  in  32  SRAM read word, valid the cycle after the address was issued
- RegWrite_out  out  1  register-file write enable
- rd_out  out  5  register-file write index
- wb_data  out  32  register-file write data, also used as the forwarding source

## Operation
Pipeline register (valid_q, pc_q, MemtoReg_q, RegWrite_q, MemRead_q, LoadUnsigned_q, Aluout_q, rd_q) update rule on each edge:
- flush=1: valid_q <= 0, other fields don't-care. Flush has priority over stall.
- else stall=1: all fields hold.
- else: load all fields from the inputs.

Hold FSM, two states:
- LIVE: load data source = data_sram_rdata. If stall && valid_q && MemRead_q!=0, capture hold_q <= data_sram_rdata and go to HELD.
- HELD: load data source = hold_q. When stall=0 or flush=1, go to LIVE. hold_q is not rewritten while in HELD.

Load alignment, with byte offset a = Aluout_q[1:0]:
- byte: selects lane a.
- half: selects lane Aluout_q[1]; a[0] is ignored, so a misaligned half truncates downward.
- word: ignores a.
- Byte and half results are sign-extended unless LoadUnsigned_q=1, then zero-extended.

Outputs:
- wb_data = aligned load data if MemtoReg_q, else Aluout_q.
- RegWrite_out = valid_q & RegWrite_q & (rd_q != 0).
- rd_out = rd_q.
- RegWrite_out stays asserted every cycle a valid instruction sits in WB, including stalled cycles. Repeated writes are idempotent.

## Timing
- Latency: MEM-stage inputs appear on outputs one cycle after the advancing edge. wb_data is combinational from the registered state and data_sram_rdata/hold_q.
- Reset (reset=0, asynchronous):
  - valid_q=0, RegWrite_q=0, MemtoReg_q=0, MemRead_q=0, rd_q=0, Aluout_q=0, hold_q=0, pc_q=RESET_PC, FSM=LIVE.
  - Hence RegWrite_out=0, rd_out=0, wb_data=0.
- Reset asserted mid-stall: FSM returns to LIVE immediately and held data is discarded.
- stall and flush in the same cycle: the bubble is inserted and FSM goes to LIVE.
- A stall on a non-load instruction does not enter HELD.
- A multi-cycle stall keeps wb_data bit-stable for the whole stall.

## Configuration
- MEM_WB_DEBUG_EN defined adds four ports: debug_wb_pc out 32 = pc_q; debug_wb_rf_wen out 4 = {4{RegWrite_out}}; debug_wb_rf_wnum out 5 = rd_out; debug_wb_rf_wdata out 32 = wb_data.
- Debug port values are 0 (debug_wb_pc = RESET_PC) in reset.
- MEM_WB_DEBUG_EN undefined: the ports and pc_q are absent and pc_in is unused. Functional behaviour is identical either way.

## Test plan
- Reset: hold reset=0 with random inputs -> RegWrite_out=0, rd_out=0, wb_data=0; release, then ADD rd=5, Aluout=32'h1234 -> next cycle RegWrite_out=1, rd_out=5, wb_data=32'h1234.
- Loads with data_sram_rdata=32'h80FF_7F01:
  - lb, Aluout=...2 -> 32'hFFFF_FFFF
  - lbu, Aluout=...3 -> 32'h0000_0080
  - lh, Aluout=...2 -> 32'hFFFF_80FF
  - lhu, Aluout=...1 -> 32'h0000_7F01
  - lw -> 32'h80FF_7F01
- Stall hold: lw enters WB with rdata=32'hCAFE_0001; assert stall 3 cycles while rdata changes to 32'hDEAD_BEEF -> wb_data stays 32'hCAFE_0001 and the FSM reads HELD. Release -> next instruction advances.
- Flush: flush=1 with valid RegWrite instruction rd=7 -> next cycle RegWrite_out=0. Repeat with stall=1 simultaneously -> same result, FSM LIVE.
- rd=0: valid RegWrite to rd=0 -> RegWrite_out=0, wb_data still = Aluout.
- Async reset during HELD: assert reset=0 mid-stall between clock edges -> outputs clear immediately without a clock, FSM LIVE.
